// File: rtl/seg_word_scanner_pkg.sv
// Shared types and constants for the scanning 7-segment word display.
// The hex table matches the existing display decoder's encoding.
package seg_word_scanner_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StGap
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index 15 is listed first: F, E, D, ... 1, 0.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg_word_scanner_decoder.sv
// Nibble to 7-segment decoder (seg[0]=a .. seg[6]=g, active-high) with a blanking gate.
module seg_word_scanner_decoder
    import seg_word_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            seg_o = hex_to_seg(nibble_i);
        end
    end

endmodule

// File: rtl/seg_word_scanner.sv
// Scans the nibbles of a snapshotted 32-bit word, MSB first, onto one 7-segment digit,
// with a dwell per digit, an optional blank gap, and a frame-done strobe.
module seg_word_scanner
    import seg_word_scanner_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned DIGITS       = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [31:0] value_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [2:0]  digit_idx_o,
    output logic        frame_done_o
);

    localparam int unsigned MaxCycles = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                                      : BLANK_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0] DigitMsb = 3'(DIGITS - 1);

    if (DWELL_CYCLES < 1 || DIGITS < 1 || DIGITS > 8) begin : gen_param_check
        $error("seg_word_scanner: DWELL_CYCLES must be >= 1 and DIGITS in 1..8");
    end

    state_e          state_q, state_d;
    logic [2:0]      digit_q, digit_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     shadow_q, shadow_d;

    logic show_last, gap_last, advance;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            digit_q  <= DigitMsb;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign show_last = (state_q == StShow) && (cnt_q == DwellLast);
    assign gap_last  = (state_q == StGap) && (cnt_q == BlankLast);
    // With no gap the digit advances straight out of its last dwell cycle.
    assign advance   = (BLANK_CYCLES == 0) ? show_last : gap_last;

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;

        if (!enable_i) begin
            state_d = StIdle;
            digit_d = DigitMsb;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d  = StShow;
                    digit_d  = DigitMsb;
                    shadow_d = value_i;
                    cnt_d    = '0;
                end
                StShow: begin
                    if (show_last) begin
                        cnt_d = '0;
                        if (BLANK_CYCLES != 0) begin
                            state_d = StGap;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    cnt_d = gap_last ? '0 : cnt_q + 1'b1;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (advance) begin
                state_d = StShow;
                cnt_d   = '0;
                if (digit_q == 3'd0) begin
                    digit_d  = DigitMsb;
                    shadow_d = value_i;
                end else begin
                    digit_d = digit_q - 3'd1;
                end
            end
        end
    end

    seg_word_scanner_decoder u_decoder (
        .nibble_i (shadow_q[{digit_q, 2'b00} +: 4]),
        .blank_i  (state_q != StShow),
        .seg_o    (seg_o)
    );

    assign dp_o         = (state_q == StShow) && (digit_q == DigitMsb);
    assign digit_idx_o  = digit_q;
    assign frame_done_o = advance && (digit_q == 3'd0);

endmodule

// File: tb/tb_seg_word_scanner.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, monitors compare at negedge.
module tb_seg_word_scanner;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en0, en1, en2;
    logic [31:0] v0, v1, v2;
    logic [6:0] seg0, seg1, seg2;
    logic dp0, dp1, dp2, fd0, fd1, fd2;
    logic [2:0] idx0, idx1, idx2;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q0[$], q1[$], q2[$];

    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seg_word_scanner #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .DIGITS(8)) u_def (
        .clk_i(clk), .reset_i(rst), .enable_i(en0), .value_i(v0),
        .seg_o(seg0), .dp_o(dp0), .digit_idx_o(idx0), .frame_done_o(fd0)
    );

    seg_word_scanner #(.DWELL_CYCLES(4), .BLANK_CYCLES(0), .DIGITS(8)) u_nogap (
        .clk_i(clk), .reset_i(rst), .enable_i(en1), .value_i(v1),
        .seg_o(seg1), .dp_o(dp1), .digit_idx_o(idx1), .frame_done_o(fd1)
    );

    seg_word_scanner #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .DIGITS(2)) u_d2 (
        .clk_i(clk), .reset_i(rst), .enable_i(en2), .value_i(v2),
        .seg_o(seg2), .dp_o(dp2), .digit_idx_o(idx2), .frame_done_o(fd2)
    );

    // Expected outputs k cycles into a frame, from the frame-layout description.
    function automatic exp_t frame_exp(int digits, int dwell, int blank, logic [31:0] snap,
                                       int k);
        exp_t e;
        int per, d, ph;
        logic [31:0] sh;
        per   = dwell + blank;
        d     = digits - 1 - k / per;
        ph    = k % per;
        sh    = snap >> (4 * d);
        e.seg = (ph < dwell) ? hex_tbl[sh[3:0]] : 7'h00;
        e.dp  = (ph < dwell) && (d == digits - 1);
        e.idx = 3'(d);
        e.fd  = (k == digits * per - 1);
        return e;
    endfunction

    function automatic exp_t idle_exp(int digits);
        exp_t e;
        e.seg = 7'h00;
        e.dp  = 1'b0;
        e.idx = 3'(digits - 1);
        e.fd  = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input int n, input exp_t e,
                         input logic [6:0] seg, input logic dp, input logic [2:0] idx,
                         input logic fd);
        n_checks++;
        if (seg !== e.seg || dp !== e.dp || idx !== e.idx || fd !== e.fd) begin
            n_fail++;
            $display("FAIL %s sample %0d: got seg=%h dp=%b idx=%0d fd=%b, want seg=%h dp=%b idx=%0d fd=%b",
                     name, n, seg, dp, idx, fd, e.seg, e.dp, e.idx, e.fd);
        end
    endtask

    int s0 = 0, s1 = 0, s2 = 0;

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            check("def", s0, q0.pop_front(), seg0, dp0, idx0, fd0);
            s0++;
        end
        if (q1.size() > 0) begin
            check("nogap", s1, q1.pop_front(), seg1, dp1, idx1, fd1);
            s1++;
        end
        if (q2.size() > 0) begin
            check("digits2", s2, q2.pop_front(), seg2, dp2, idx2, fd2);
            s2++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] snaps [4] = '{32'h12345678, 32'hDEADBEEF, 32'h00000000, 32'h00000000};

    initial begin
        rst = 1'b1;
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        v0 = 32'hFFFFFFFF; v1 = 32'hFFFFFFFF; v2 = 32'hFFFFFFFF;

        // Reset wins over enable.
        repeat (3) begin
            step();
            q0.push_back(idle_exp(8));
            q1.push_back(idle_exp(8));
            q2.push_back(idle_exp(2));
        end
        rst = 1'b0;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        step();
        q0.push_back(idle_exp(8));
        q1.push_back(idle_exp(8));
        q2.push_back(idle_exp(2));

        // Normal scan, snapshot coherence, then abort during digit 4 of the fourth frame.
        v0  = 32'h12345678;
        en0 = 1'b1;
        for (int t = 1; t <= 164; t++) begin
            step();
            q0.push_back(frame_exp(8, 4, 2, snaps[(t - 1) / 48], (t - 1) % 48));
            if (t == 40) v0 = 32'hDEADBEEF;
            if (t == 58) v0 = 32'h00000000;
        end
        en0 = 1'b0;
        repeat (2) begin
            step();
            q0.push_back(idle_exp(8));
        end
        v0  = 32'hA0000000;
        en0 = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            q0.push_back(frame_exp(8, 4, 2, 32'hA0000000, t));
        end
        en0 = 1'b0;

        // No-gap instance.
        v1  = 32'h88888888;
        en1 = 1'b1;
        for (int t = 1; t <= 70; t++) begin
            step();
            q1.push_back(frame_exp(8, 4, 0, 32'h88888888, (t - 1) % 32));
        end
        en1 = 1'b0;

        // Two-digit instance: upper nibbles never appear.
        v2  = 32'hFFFF00C3;
        en2 = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            step();
            q2.push_back(frame_exp(2, 4, 2, 32'hFFFF00C3, (t - 1) % 12));
        end
        en2 = 1'b0;

        @(negedge clk);
        #1;
        n_checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending samples, want 0",
                     q0.size() + q1.size() + q2.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
